// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO controllers.
// Gray/binary conversion and the pointer width convention.
package fifo_pkg;

  localparam int MAXW = 32;

  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

  function automatic logic [MAXW-1:0] bin2gray(
    input logic [MAXW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB; zero-extended inputs convert correctly.
  function automatic logic [MAXW-1:0] gray2bin(
    input logic [MAXW-1:0] g
  );
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for Gray pointers crossing clock domains.
// Shared by the read- and write-side controllers.
module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Async FIFO read-side controller: read pointers, empty/level flags.
// Define FIFO_RD_UNDERFLOW_EN to build the sticky underflow flag.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   wptr,
  output logic [ASIZE-1:0] raddr,
  output logic             ren,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam int PTR_W = ptr_w(ASIZE);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rq2_wptr;
  logic [PTR_W-1:0] rbinnext;
  logic [PTR_W-1:0] rgraynext;
  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] level_next;

  fifo_sync_2ff #(
    .WIDTH(PTR_W)
  ) u_sync (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .d      (wptr),
    .q      (rq2_wptr)
  );

  assign ren        = rinc & ~rempty;
  assign raddr      = rbin[ASIZE-1:0];
  assign rbinnext   = rbin + PTR_W'(ren);
  assign rgraynext  = PTR_W'(bin2gray(MAXW'(rbinnext)));
  assign wbin_s     = PTR_W'(gray2bin(MAXW'(rq2_wptr)));
  // Modulo difference; a full FIFO reads as exactly 2^ASIZE.
  assign level_next = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (level_next <= PTR_W'(AE_THRESH));
      rlevel        <= level_next;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc & rempty) begin
      runderflow <= 1'b1;
    end
  end
`else
  assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Scoreboard bench for the async FIFO read-side controller.
// Expected read addresses are queued per write and popped per read.
module tb_fifo_rptr_empty;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] wptr;
  logic [3:0] raddr;
  logic       ren;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int total = 0;
  int passed = 0;
  int wcnt = 0;
  int q[$];
  logic [4:0] saved;

`ifdef FIFO_RD_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  fifo_rptr_empty #(
    .ASIZE(4),
    .AE_THRESH(2)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .wptr          (wptr),
    .raddr         (raddr),
    .ren           (ren),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] g(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_to(input int n);
    while (wcnt < n) begin
      q.push_back(wcnt % 16);
      wcnt++;
    end
    wptr = g(wcnt);
  endtask

  task automatic pop();
    int want;
    rinc = 1'b1;
    #1;
    total++;
    if (ren !== 1'b1) $display("FAIL pop_ren got %b want 1", ren);
    else passed++;
    total++;
    if (q.size() == 0) begin
      $display("FAIL pop_sb got raddr %0d want no read", raddr);
    end else begin
      want = q.pop_front();
      if (raddr !== want[3:0])
        $display("FAIL pop_raddr got %0d want %0d", raddr, want);
      else passed++;
    end
    cyc();
    rinc = 1'b0;
  endtask

  task automatic start_empty();
    rrst_n = 1'b0;
    rinc = 1'b0;
    q.delete();
    wcnt = 0;
    wptr = 5'd0;
    cyc();
    cyc();
    rrst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    rinc = 1'b0;
    q.delete();
    wcnt = 0;
    write_to(4);
    cyc();
    cyc();
    total++;
    if ({rempty, ralmost_empty, rlevel, rptr, raddr, runderflow}
        !== {1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0})
      $display("FAIL reset_vals got e%b ae%b lv%0d p%0d a%0d u%b want 1 1 0 0 0 0",
               rempty, ralmost_empty, rlevel, rptr, raddr, runderflow);
    else passed++;
    rrst_n = 1'b1;
    cyc();
    total++;
    if (rempty !== 1'b1) $display("FAIL rel_edge1 got %b want 1", rempty);
    else passed++;
    cyc();
    total++;
    if (rempty !== 1'b1) $display("FAIL rel_edge2 got %b want 1", rempty);
    else passed++;
    cyc();
    total++;
    if (rempty !== 1'b0 || rlevel !== 5'd4)
      $display("FAIL rel_edge3 got e%b lv%0d want 0 4", rempty, rlevel);
    else passed++;
  endtask

  task automatic test_almost_empty();
    total++;
    if (ralmost_empty !== 1'b0)
      $display("FAIL ae_lv4 got %b want 0", ralmost_empty);
    else passed++;
    pop();
    pop();
    total++;
    if ({rlevel, ralmost_empty, rempty} !== {5'd2, 1'b1, 1'b0})
      $display("FAIL ae_lv2 got lv%0d ae%b e%b want 2 1 0",
               rlevel, ralmost_empty, rempty);
    else passed++;
    pop();
    total++;
    if ({rlevel, ralmost_empty, rempty} !== {5'd1, 1'b1, 1'b0})
      $display("FAIL ae_lv1 got lv%0d ae%b e%b want 1 1 0",
               rlevel, ralmost_empty, rempty);
    else passed++;
    pop();
    total++;
    if (rempty !== 1'b1) $display("FAIL ae_lv0 got %b want 1", rempty);
    else passed++;
  endtask

  task automatic test_mid_reset();
    write_to(8);
    cyc();
    cyc();
    cyc();
    total++;
    if (rlevel !== 5'd4) $display("FAIL mid_pre got %0d want 4", rlevel);
    else passed++;
    rrst_n = 1'b0;
    #1;
    total++;
    if ({rempty, ralmost_empty, rlevel, rptr} !== {1'b1, 1'b1, 5'd0, 5'd0})
      $display("FAIL mid_reset got e%b ae%b lv%0d p%0d want 1 1 0 0",
               rempty, ralmost_empty, rlevel, rptr);
    else passed++;
  endtask

  task automatic test_fill_drain();
    start_empty();
    for (int k = 1; k <= 16; k++) begin
      write_to(k);
      cyc();
    end
    cyc();
    cyc();
    cyc();
    total++;
    if ({rlevel, rempty, ralmost_empty} !== {5'd16, 1'b0, 1'b0})
      $display("FAIL full got lv%0d e%b ae%b want 16 0 0",
               rlevel, rempty, ralmost_empty);
    else passed++;
    for (int k = 0; k < 16; k++) pop();
    total++;
    if ({rempty, rptr, rlevel} !== {1'b1, 5'b11000, 5'd0})
      $display("FAIL drained got e%b p%b lv%0d want 1 11000 0",
               rempty, rptr, rlevel);
    else passed++;
  endtask

  task automatic test_wrap();
    start_empty();
    write_to(15);
    cyc();
    cyc();
    cyc();
    for (int k = 0; k < 15; k++) pop();
    write_to(18);
    cyc();
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) pop();
    total++;
    if (rptr !== g(18) || rptr[4] !== 1'b1 || rempty !== 1'b1)
      $display("FAIL wrap got p%b e%b want %b 1", rptr, rempty, g(18));
    else passed++;
  endtask

  task automatic test_underflow();
    saved = rptr;
    rinc = 1'b1;
    #1;
    total++;
    if (ren !== 1'b0) $display("FAIL uf_ren got %b want 0", ren);
    else passed++;
    cyc();
    cyc();
    total++;
    if (rptr !== saved) $display("FAIL uf_ptr got %b want %b", rptr, saved);
    else passed++;
    total++;
    if (runderflow !== UF_EXP)
      $display("FAIL uf_set got %b want %b", runderflow, UF_EXP);
    else passed++;
    rinc = 1'b0;
    cyc();
    cyc();
    total++;
    if (runderflow !== UF_EXP)
      $display("FAIL uf_sticky got %b want %b", runderflow, UF_EXP);
    else passed++;
    rrst_n = 1'b0;
    #1;
    total++;
    if (runderflow !== 1'b0) $display("FAIL uf_clear got %b want 0", runderflow);
    else passed++;
  endtask

  task automatic test_simultaneous();
    start_empty();
    write_to(1);
    cyc();
    cyc();
    cyc();
    total++;
    if (rempty !== 1'b0 || rlevel !== 5'd1)
      $display("FAIL sim_pre got e%b lv%0d want 0 1", rempty, rlevel);
    else passed++;
    write_to(2);
    cyc();
    pop();
    total++;
    if (rempty !== 1'b1) $display("FAIL sim_pessimistic got %b want 1", rempty);
    else passed++;
    cyc();
    total++;
    if (rempty !== 1'b0 || rlevel !== 5'd1)
      $display("FAIL sim_next got e%b lv%0d want 0 1", rempty, rlevel);
    else passed++;
    pop();
    total++;
    if (rempty !== 1'b1 || q.size() != 0)
      $display("FAIL sim_drain got e%b left%0d want 1 0", rempty, q.size());
    else passed++;
  endtask

  initial begin
    rinc = 1'b0;
    wptr = 5'd0;
    test_reset();
    test_almost_empty();
    test_mid_reset();
    test_fill_drain();
    test_wrap();
    test_underflow();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
Read-domain controller of the asynchronous FIFO. It consumes the write pointer, which arrives Gray-coded from the write domain, and synchronises it into rclk. It maintains the binary and Gray read pointers and drives the read address and read enable of the dual-port memory. It also generates registered empty, almost-empty and fill-level status for the reader.

Parameters:
ASIZE, 4, memory address bits; FIFO depth = 2^ASIZE; pointers are ASIZE+1 bits.
AE_THRESH, 2, almost-empty asserts when level <= AE_THRESH; legal range 0..2^ASIZE-1.

Ports:
rclk  input  1  read-domain clock; the only clock in this block.
rrst_n  input  1  asynchronous, active-low reset.
rinc  input  1  reader pop request; honoured only when rempty=0.
wptr  input  ASIZE+1  write pointer, Gray-coded, from the write domain; treated as asynchronous.
raddr  output  ASIZE  memory read address (binary, lower ASIZE bits of the read pointer).
ren  output  1  memory read enable (combinational) = rinc & ~rempty.
rptr  output  ASIZE+1  registered Gray read pointer, sent to the write domain.
rempty  output  1  registered empty flag.
ralmost_empty  output  1  registered almost-empty flag.
rlevel  output  ASIZE+1  registered occupancy as seen from the read domain, 0..2^ASIZE.
runderflow  output  1  sticky underflow flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst_n is asynchronous and active-low.
- Reset values: rbin=0, rptr=0, both sync stages=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
- Reset mid-operation: asserting rrst_n low immediately forces all of the reset values above, whatever the pointer state. Deassertion is assumed to be synchronised externally.
- Synchroniser: wptr passes through 2 flops on rclk to give rq2_wptr. Write-to-visible latency is 2 rclk cycles after wptr changes, plus 1 cycle for the flags.
- Pointer update:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2^(ASIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
  - rbin and rptr load rbinnext and rgraynext every rclk edge.
- Wrap-around: the pointer MSB toggles on each pass through the memory. raddr = rbin[ASIZE-1:0] wraps from 2^ASIZE-1 to 0 with no special case.
- Empty: rempty <= (rgraynext == rq2_wptr). It asserts on the same edge that pops the last word, so there is no extra-cycle bubble. It deasserts 1 cycle after rq2_wptr differs from rgraynext.
- Level:
  - wbin_s = gray-to-binary(rq2_wptr).
  - rlevel <= wbin_s - rbinnext, ASIZE+1 bits, unsigned modulo arithmetic.
  - A value of 2^ASIZE is legal and means full.
- Almost-empty: ralmost_empty <= (wbin_s - rbinnext) <= AE_THRESH. It shares the rlevel subtraction and is updated on the same edge as rempty.
- Memory read: ren and raddr are combinational from the current rbin and rempty. The memory returns data either combinationally (fall-through) or one cycle later (sync read). This block is agnostic to which read mode the memory uses.
- Pop while empty (rinc=1, rempty=1): no pointer change and ren=0. This event sets runderflow when the underflow feature is enabled.
- Simultaneous pop and write arrival: the pop is applied to rbinnext, and the new rq2_wptr is compared against rgraynext on the same edge. The flags are therefore conservative (pessimistic empty) and never optimistic.
- rptr changes by at most one bit per cycle, so it is safe to synchronise into the write domain.

Optional Feature:
Macro: FIFO_RD_UNDERFLOW_EN.
- Defined: runderflow is set on any rclk edge where rinc & rempty is true. It stays set until rrst_n is asserted.
- Undefined: no underflow logic is built, and runderflow is tied to 0.

Decomposition:
- Shared package fifo_pkg holds:
  - a bin2gray function;
  - a gray2bin function (prefix XOR, parameterised width);
  - the PTR_W = ASIZE+1 width convention.
- One sub-module, fifo_sync_2ff: WIDTH parameter, rclk, rrst_n, d, q, two-flop synchroniser. It is reused by the write-side controller.

Test Plan:
- Reset: hold rrst_n=0 with wptr=5'b00110 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, raddr=0. After release, rempty falls on the 3rd rclk edge.
- Fill then drain, ASIZE=4:
  - stimulus: wptr steps through Gray codes of 1..16; then 16 pops.
  - required: rlevel settles to 16; raddr runs 0..15 with ren=1 on each pop; rempty=1 on the edge of the 16th pop; rptr = Gray(16) = 5'b11000.
- Wrap-around:
  - stimulus: rbin at 15, write pointer at Gray(18); three pops.
  - required: raddr sequence 15, 0, 1; rbin MSB set; rempty=1 after the third pop.
- Almost-empty, AE_THRESH=2, level 4: pop twice -> ralmost_empty rises with rlevel=2 and rempty=0; one more pop -> rlevel=1, still almost-empty.
- Underflow with FIFO_RD_UNDERFLOW_EN defined: rinc=1 while empty -> ren=0, rbin unchanged, runderflow=1 and remains 1 until reset. With the macro undefined, runderflow stays 0.
- Simultaneous events: single-word FIFO, pop on the same edge that a new wptr reaches rq2_wptr -> rempty=0 the next cycle and rlevel=1; no word is lost or double-read.
